// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit -- single-outstanding instruction fetch with redirect squash and
// a one-entry skid buffer.                                       Rev 1.0
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  pc_branch_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             if_valid_o,
  output logic [XLEN-1:0]  if_pc_o,
  output logic [31:0]      if_instr_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [1:0]      state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [31:0]     skid_instr_q;
  logic            kill_q;
  logic            valid_q;
  logic [XLEN-1:0] out_pc_q;
  logic [31:0]     out_instr_q;

  logic take_rsp;
  logic slot_free;
  logic load_rsp;
  logic load_skid;

  // A response is only usable if it is neither already marked wrong-path nor
  // being squashed by a redirect arriving in the same cycle.
  assign take_rsp  = (state_q == WAIT) && imem_rvalid_i && !kill_q && !branch_taken_i;
  assign slot_free = !valid_q || !stall_i;
  assign load_rsp  = take_rsp && slot_free;
  assign load_skid = (state_q == HOLD) && !branch_taken_i && !stall_i;

  assign imem_req_o  = (state_q == REQ);
  assign imem_addr_o = pc_q;
  assign if_valid_o  = valid_q;
  assign if_pc_o     = out_pc_q;
  assign if_instr_o  = out_instr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      kill_q       <= 1'b0;
    end else begin
      if (branch_taken_i) begin
        pc_q <= pc_branch_i;
      end
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (imem_gnt_i) begin
            req_pc_q <= pc_q;
            kill_q   <= branch_taken_i;
            state_q  <= WAIT;
            if (!branch_taken_i) begin
              pc_q <= pc_q + PC_STEP;
            end
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            kill_q <= 1'b0;
            if (take_rsp && !slot_free) begin
              skid_pc_q    <= req_pc_q;
              skid_instr_q <= imem_rdata_i;
              state_q      <= HOLD;
            end else begin
              state_q <= REQ;
            end
          end else if (branch_taken_i) begin
            kill_q <= 1'b1;
          end
        end
        HOLD: begin
          if (branch_taken_i || !stall_i) begin
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Redirect outranks everything, including a stalled decode stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= NOP_INSTR;
    end else if (branch_taken_i) begin
      valid_q     <= 1'b0;
      out_instr_q <= NOP_INSTR;
    end else if (load_rsp) begin
      valid_q     <= 1'b1;
      out_pc_q    <= req_pc_q;
      out_instr_q <= imem_rdata_i;
    end else if (load_skid) begin
      valid_q     <= 1'b1;
      out_pc_q    <= skid_pc_q;
      out_instr_q <= skid_instr_q;
    end else if (!stall_i) begin
      valid_q     <= 1'b0;
      out_instr_q <= NOP_INSTR;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_unit -- scoreboard bench for fetch_unit.               Rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } out_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic [31:0] pc_branch;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] if_pc;
  logic [31:0] instr;

  logic        w_stall;
  logic        w_branch;
  logic [31:0] w_pc_branch;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_gnt;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_instr;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  out_t        exp_out_q[$];
  logic [31:0] w_exp_addr_q[$];
  out_t        w_exp_out_q[$];

  logic [31:0] a_exp;
  out_t        o_exp;
  logic [31:0] wa_exp;
  out_t        wo_exp;

  int          mem_lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        w_pend = 1'b0;
  logic [31:0] w_pend_addr = '0;

  fetch_unit dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .stall_i        (stall),
    .branch_taken_i (branch),
    .pc_branch_i    (pc_branch),
    .imem_req_o     (req),
    .imem_addr_o    (addr),
    .imem_gnt_i     (gnt),
    .imem_rvalid_i  (rvalid),
    .imem_rdata_i   (rdata),
    .if_valid_o     (valid),
    .if_pc_o        (if_pc),
    .if_instr_o     (instr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .stall_i        (w_stall),
    .branch_taken_i (w_branch),
    .pc_branch_i    (w_pc_branch),
    .imem_req_o     (w_req),
    .imem_addr_o    (w_addr),
    .imem_gnt_i     (w_gnt),
    .imem_rvalid_i  (w_rvalid),
    .imem_rdata_i   (w_rdata),
    .if_valid_o     (w_valid),
    .if_pc_o        (w_if_pc),
    .if_instr_o     (w_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h5A00_0000 + a;
  endfunction

  // Memory model: response arrives mem_lat cycles after the grant.
  initial begin
    rvalid = 1'b0;
    rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && req && gnt) begin
        pend_addr = addr;
        pend_cnt  = mem_lat;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend_cnt = 0;
        rvalid   = 1'b0;
      end else if (pend_cnt > 0) begin
        pend_cnt = pend_cnt - 1;
        rvalid   = (pend_cnt == 0);
        rdata    = rvalid ? mem_word(pend_addr) : 32'h0;
      end else begin
        rvalid = 1'b0;
      end
    end
  end

  initial begin
    w_rvalid = 1'b0;
    w_rdata  = '0;
    forever begin
      @(negedge clk);
      w_pend      = rst_n && w_req && w_gnt;
      w_pend_addr = w_addr;
      @(posedge clk);
      #1;
      w_rvalid = w_pend && rst_n;
      w_rdata  = mem_word(w_pend_addr);
    end
  end

  // Request-address monitor.
  initial forever begin
    @(negedge clk);
    if (rst_n && req && gnt) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL req_addr: unexpected request at %h", addr);
      end else begin
        a_exp = exp_addr_q.pop_front();
        if (addr !== a_exp) begin
          errors++;
          $display("FAIL req_addr: got %h expected %h", addr, a_exp);
        end
      end
    end
  end

  // Output monitor: an instruction counts once decode actually takes it.
  initial forever begin
    @(negedge clk);
    if (rst_n && valid && !stall && !branch) begin
      checks++;
      if (exp_out_q.size() == 0) begin
        errors++;
        $display("FAIL if_out: unexpected pc=%h instr=%h", if_pc, instr);
      end else begin
        o_exp = exp_out_q.pop_front();
        if (if_pc !== o_exp.pc || instr !== o_exp.instr) begin
          errors++;
          $display("FAIL if_out: got pc=%h instr=%h expected pc=%h instr=%h",
                   if_pc, instr, o_exp.pc, o_exp.instr);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && w_req && w_gnt && w_exp_addr_q.size() > 0) begin
      checks++;
      wa_exp = w_exp_addr_q.pop_front();
      if (w_addr !== wa_exp) begin
        errors++;
        $display("FAIL wrap_addr: got %h expected %h", w_addr, wa_exp);
      end
    end
    if (rst_n && w_valid && w_exp_out_q.size() > 0) begin
      checks++;
      wo_exp = w_exp_out_q.pop_front();
      if (w_if_pc !== wo_exp.pc || w_instr !== wo_exp.instr) begin
        errors++;
        $display("FAIL wrap_out: got pc=%h instr=%h expected pc=%h instr=%h",
                 w_if_pc, w_instr, wo_exp.pc, wo_exp.instr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(input logic [31:0] a);
    for (int n = 0; n < 60; n++) begin
      step();
      if (req && addr == a) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_req: no request at %h within 60 cycles (req=%b addr=%h)", a, req, addr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " imem_req"}, {31'd0, req}, 32'd0);
    check({tag, " imem_addr"}, addr, 32'h0);
    check({tag, " if_valid"}, {31'd0, valid}, 32'd0);
    check({tag, " if_pc"}, if_pc, 32'h0);
    check({tag, " if_instr"}, instr, 32'h0000_0013);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    branch      = 1'b0;
    pc_branch   = '0;
    gnt         = 1'b1;
    w_stall     = 1'b0;
    w_branch    = 1'b0;
    w_pc_branch = '0;
    w_gnt       = 1'b1;

    w_exp_addr_q.push_back(32'hFFFF_FFFC);
    w_exp_addr_q.push_back(32'h0000_0000);
    w_exp_out_q.push_back('{pc: 32'hFFFF_FFFC, instr: 32'h59FF_FFFC});

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Straight-line fetch from 0.
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_out_q.push_back('{pc: 32'h0, instr: 32'h5A00_0000});
    exp_out_q.push_back('{pc: 32'h4, instr: 32'h5A00_0004});
    step();
    rst_n = 1'b1;

    // Redirect while the 0x8 fetch is outstanding.
    wait_req(32'h8);
    mem_lat = 2;
    step();
    branch    = 1'b1;
    pc_branch = 32'h100;
    exp_addr_q.push_back(32'h100);
    exp_out_q.push_back('{pc: 32'h100, instr: 32'h5A00_0100});
    step();
    branch  = 1'b0;
    mem_lat = 1;
    check("squash_wait if_valid", {31'd0, valid}, 32'd0);

    // Redirect in the same cycle as a grant.
    wait_req(32'h104);
    gnt = 1'b0;
    step();
    check("no_gnt addr_hold", addr, 32'h104);
    check("no_gnt req_hold", {31'd0, req}, 32'd1);
    gnt       = 1'b1;
    branch    = 1'b1;
    pc_branch = 32'h200;
    exp_addr_q.push_back(32'h104);
    exp_addr_q.push_back(32'h200);
    exp_out_q.push_back('{pc: 32'h200, instr: 32'h5A00_0200});
    step();
    branch = 1'b0;

    // Stall five cycles while the next response lands in the skid buffer.
    wait_req(32'h204);
    stall = 1'b1;
    exp_addr_q.push_back(32'h204);
    repeat (3) step();
    check("hold imem_req", {31'd0, req}, 32'd0);
    check("hold if_valid", {31'd0, valid}, 32'd1);
    check("hold if_pc", if_pc, 32'h200);
    check("hold if_instr", instr, 32'h5A00_0200);
    step();
    step();
    stall = 1'b0;
    step();
    check("skid if_valid", {31'd0, valid}, 32'd1);
    check("skid if_pc", if_pc, 32'h204);
    check("skid if_instr", instr, 32'h5A00_0204);
    check("skid next req", {31'd0, req}, 32'd1);
    check("skid next addr", addr, 32'h208);

    // Stall and redirect together with a filled skid buffer.
    stall = 1'b1;
    exp_addr_q.push_back(32'h208);
    exp_addr_q.push_back(32'h300);
    exp_out_q.push_back('{pc: 32'h300, instr: 32'h5A00_0300});
    step();
    step();
    check("stall_br hold req", {31'd0, req}, 32'd0);
    branch    = 1'b1;
    pc_branch = 32'h300;
    step();
    branch = 1'b0;
    stall  = 1'b0;
    check("stall_br if_valid", {31'd0, valid}, 32'd0);
    check("stall_br if_instr", instr, 32'h0000_0013);
    check("stall_br req", {31'd0, req}, 32'd1);
    check("stall_br addr", addr, 32'h300);

    // Asynchronous reset while waiting on a response.
    wait_req(32'h304);
    exp_addr_q.push_back(32'h304);
    step();
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) step();
    exp_addr_q.push_back(32'h0);
    exp_out_q.push_back('{pc: 32'h0, instr: 32'h5A00_0000});
    rst_n = 1'b1;
    wait_req(32'h4);
    gnt = 1'b0;
    repeat (3) step();

    check("main addr queue drained", exp_addr_q.size(), 32'd0);
    check("main out queue drained", exp_out_q.size(), 32'd0);
    check("wrap addr queue drained", w_exp_addr_q.size(), 32'd0);
    check("wrap out queue drained", w_exp_out_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the program counter.
- Issues one instruction-memory request at a time over a req/gnt/rvalid handshake and presents {pc, instr, valid} to decode.
- Consumes the redirect (branch_taken, target PC) produced by the execute-stage branch logic. Squashes wrong-path fetches, both in flight and already buffered.
- Non-pipelined: at most one outstanding request, so peak throughput is 1 instruction per 2 cycles.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value held on if_instr_o when no valid instruction is presented.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- stall_i  input  1  decode cannot accept; hold the presented instruction.
- branch_taken_i  input  1  redirect request from execute.
- pc_branch_i  input  XLEN  redirect target; valid when branch_taken_i=1.
- imem_req_o  output  1  memory request valid.
- imem_addr_o  output  XLEN  request address; equals pc_q.
- imem_gnt_i  input  1  memory accepts request this cycle.
- imem_rvalid_i  input  1  read data valid; no earlier than the cycle after gnt.
- imem_rdata_i  input  32  read data.
- if_valid_o  output  1  instruction presented to decode.
- if_pc_o  output  XLEN  PC of the presented instruction.
- if_instr_o  output  32  presented instruction.

Behaviour:
Reset (async, rst_ni low):
- state=IDLE, pc_q=RESET_PC, kill_q=0.
- Outputs: imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_instr_o=NOP_INSTR.
- Reset mid-transaction: the outstanding response is forgotten; the memory must also be reset.

State machine, states IDLE, REQ, WAIT, HOLD:
- IDLE: imem_req_o=0. Always moves to REQ on the next cycle.
- REQ: imem_req_o=1, imem_addr_o=pc_q.
  - On gnt: latch req_pc_q=pc_q, set pc_q=pc_q+4 (modulo 2^XLEN, wraps silently), go to WAIT.
  - Without gnt: remain in REQ. The address may change only due to a redirect.
- WAIT: imem_req_o=0. On rvalid:
  - If kill_q or branch_taken_i: discard the data, clear kill_q, go to REQ.
  - Else if the output slot is free (if_valid_o=0 or stall_i=0): load {req_pc_q, rdata} into the output, if_valid_o=1, go to REQ.
  - Else: store the data in the skid register, go to HOLD.
- HOLD: imem_req_o=0.
  - When stall_i=0: the output takes the skid contents (valid=1), go to REQ.

Redirect (branch_taken_i=1), which has priority over stall_i and pc+4:
- pc_q<=pc_branch_i. In REQ, imem_addr_o shows the new target from the next cycle.
- REQ with gnt in the same cycle: the granted request is wrong-path. Set kill_q=1 and go to WAIT; pc_q still takes pc_branch_i.
- WAIT without rvalid: set kill_q=1.
- HOLD: discard the skid, go to REQ.
- Output register: if_valid_o<=0 and if_instr_o<=NOP_INSTR next cycle, even if stall_i=1.

Output register without redirect:
- stall_i=1: hold all three outputs unchanged.
- stall_i=0 and no new data: if_valid_o<=0, if_instr_o<=NOP_INSTR, if_pc_o holds.

Other rules:
- Redirect targets are not alignment-checked; bits [1:0] pass through unchanged.
- Nothing is ever presented with if_valid_o=1 from a wrong path after a redirect.

Test Plan:
- Reset release, gnt tied high, rvalid one cycle after gnt -> addresses 0x0, 0x4, 0x8. if_valid_o pulses with if_pc_o=0x0 then 0x4; if_instr_o matches the memory words.
- Redirect in WAIT: fetch at 0x8 outstanding, branch_taken_i=1 with pc_branch_i=0x100 -> the 0x8 response is dropped (if_valid_o stays 0); next request is addr 0x100; 0x100 is presented.
- Redirect in the same cycle as gnt at 0x10 -> the response for 0x10 is dropped; next imem_addr_o=0x200 when pc_branch_i=0x200.
- stall_i=1 for 5 cycles with instr@0x4 presented, response @0x8 arrives -> state HOLD, imem_req_o=0, outputs frozen at 0x4. After stall_i drops, 0x8 is presented the next cycle, then a request is issued at 0xC.
- Stall plus redirect together: stall_i=1 and branch_taken_i=1 while if_valid_o=1 -> if_valid_o=0 and if_instr_o=0x13 next cycle; the skid is discarded.
- PC wrap: RESET_PC=0xFFFF_FFFC -> second request address is 0x0000_0000.
- Async reset asserted in WAIT -> outputs reach their reset values immediately, without a clock edge.
